// File: rtl/prng_lfsr_stream.sv
// prng_lfsr_stream
//   Parametrised Fibonacci LFSR pseudo-random generator with a single-clock
//   step-enable divider, seed loading with zero-seed substitution and a packed
//   keystream output using valid/ready backpressure.
//   Optional feature macro: PRNG_LFSR_STREAM_STEP_CNT_EN adds o_step_cnt[63:0],
//   a saturating count of LFSR steps since the last reset or seed load.
module prng_lfsr_stream #(
  parameter int                WIDTH        = 128,
  parameter int                DIV_N        = 8,
  parameter int                OUT_W        = 8,
  parameter logic [WIDTH-1:0]  DEFAULT_SEED = {WIDTH{1'b1}}
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_seed_load,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_en,
  output logic [OUT_W-1:0] o_ks_data,
  output logic             o_ks_valid,
  input  logic             i_ks_ready,
  output logic [WIDTH-1:0] o_lfsr,
  output logic             o_keystream,
  output logic             o_seed_zero,
  output logic             o_running
`ifdef PRNG_LFSR_STREAM_STEP_CNT_EN
  ,
  output logic [63:0]      o_step_cnt
`endif
);

  localparam int DIV_W  = (DIV_N > 1) ? $clog2(DIV_N) : 1;
  localparam int BIT_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int PACK_W = (OUT_W > 1) ? OUT_W - 1 : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_N - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OUT_W - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   lfsr_reg, lfsr_next;
  logic [DIV_W-1:0]   div_cnt_reg, div_cnt_next;
  logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [PACK_W-1:0]  pack_reg, pack_next;
  logic [OUT_W-1:0]   ks_data_reg, ks_data_next;
  logic               ks_valid_reg, ks_valid_next;
  logic               seed_zero_reg, seed_zero_next;

  logic               fb;
  logic               ks;
  logic               stall;
  logic               advance;
  logic               tick;
  logic               step;
  logic               seed_is_zero;
  logic [WIDTH-1:0]   seed_value;
  logic [OUT_W-1:0]   pack_shift;
  logic [PACK_W-1:0]  pack_keep;

  // Parameter legality and tap selection are resolved at elaboration time.
  generate
    if (WIDTH == 128) begin : g_taps128
      assign fb = lfsr_reg[127] ^ lfsr_reg[125] ^ lfsr_reg[100] ^ lfsr_reg[98];
    end else if (WIDTH == 64) begin : g_taps64
      assign fb = lfsr_reg[63] ^ lfsr_reg[62] ^ lfsr_reg[60] ^ lfsr_reg[59];
    end else if (WIDTH == 32) begin : g_taps32
      assign fb = lfsr_reg[31] ^ lfsr_reg[21] ^ lfsr_reg[1] ^ lfsr_reg[0];
    end else begin : g_bad_width
      $error("prng_lfsr_stream: WIDTH must be 32, 64 or 128");
      assign fb = 1'b0;
    end

    if (DIV_N < 1) begin : g_bad_div
      $error("prng_lfsr_stream: DIV_N must be at least 1");
    end

    if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
      $error("prng_lfsr_stream: OUT_W must be in 1..WIDTH");
    end

    // The pack register only needs the OUT_W-1 older bits; the newest bit is
    // the one emitted by the current step.
    if (OUT_W == 1) begin : g_pack1
      assign pack_shift = ks;
      assign pack_keep  = 1'b0;
    end else begin : g_packn
      assign pack_shift = {pack_reg, ks};
      assign pack_keep  = pack_shift[OUT_W-2:0];
    end
  endgenerate

  assign ks           = lfsr_reg[WIDTH-1];
  assign stall        = ks_valid_reg && !i_ks_ready;
  assign advance      = (state_reg == ST_RUN) && i_en && !stall;
  assign tick         = (div_cnt_reg == DIV_LAST);
  assign step         = advance && tick;
  assign seed_is_zero = (i_seed == '0);
  assign seed_value   = seed_is_zero ? DEFAULT_SEED : i_seed;

  // FSM next state: any seed load enters (or restarts) RUN; nothing leaves it but reset.
  always_comb begin
    state_next = state_reg;
    if (i_seed_load) begin
      state_next = ST_RUN;
    end
  end

  // Datapath next state: seed load overrides stepping and drops any pending word.
  always_comb begin
    lfsr_next      = lfsr_reg;
    div_cnt_next   = div_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    pack_next      = pack_reg;
    ks_data_next   = ks_data_reg;
    ks_valid_next  = ks_valid_reg;
    seed_zero_next = 1'b0;

    if (i_seed_load) begin
      lfsr_next      = seed_value;
      div_cnt_next   = '0;
      bit_cnt_next   = '0;
      pack_next      = '0;
      ks_valid_next  = 1'b0;
      seed_zero_next = seed_is_zero;
    end else begin
      // A consumed word clears valid unless a fresh word lands in the same cycle below.
      if (ks_valid_reg && i_ks_ready) begin
        ks_valid_next = 1'b0;
      end

      if (advance) begin
        div_cnt_next = tick ? '0 : div_cnt_reg + DIV_W'(1);
      end

      if (step) begin
        lfsr_next = {lfsr_reg[WIDTH-2:0], fb};
        pack_next = pack_keep;
        if (bit_cnt_reg == BIT_LAST) begin
          ks_data_next  = pack_shift;
          ks_valid_next = 1'b1;
          bit_cnt_next  = '0;
        end else begin
          bit_cnt_next = bit_cnt_reg + BIT_W'(1);
        end
      end
    end
  end

  // State register with synchronous reset back to IDLE and the default seed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= ST_IDLE;
      lfsr_reg      <= DEFAULT_SEED;
      div_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      pack_reg      <= '0;
      ks_data_reg   <= '0;
      ks_valid_reg  <= 1'b0;
      seed_zero_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lfsr_reg      <= lfsr_next;
      div_cnt_reg   <= div_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      pack_reg      <= pack_next;
      ks_data_reg   <= ks_data_next;
      ks_valid_reg  <= ks_valid_next;
      seed_zero_reg <= seed_zero_next;
    end
  end

`ifdef PRNG_LFSR_STREAM_STEP_CNT_EN
  logic [63:0] step_cnt_reg;

  // Saturating step counter, cleared by reset and by every seed load.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_seed_load) begin
      step_cnt_reg <= '0;
    end else if (step && (step_cnt_reg != {64{1'b1}})) begin
      step_cnt_reg <= step_cnt_reg + 64'd1;
    end
  end

  assign o_step_cnt = step_cnt_reg;
`endif

  assign o_ks_data   = ks_data_reg;
  assign o_ks_valid  = ks_valid_reg;
  assign o_lfsr      = lfsr_reg;
  assign o_keystream = lfsr_reg[WIDTH-1];
  assign o_seed_zero = seed_zero_reg;
  assign o_running   = (state_reg == ST_RUN);

endmodule

// File: tb/tb_prng_lfsr_stream.sv
// Testbench for prng_lfsr_stream: a 32-bit DIV_N=1 instance and a 128-bit
// DIV_N=4 instance, checked against a bit-queue style reference model every
// cycle plus constant vectors and hand-written multi-cycle sequences.
module tb_prng_lfsr_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=32, DIV_N=1, OUT_W=8
  logic        a_rst, a_load, a_en, a_ready;
  logic [31:0] a_seed;
  logic [7:0]  a_data;
  logic        a_valid, a_ks, a_sz, a_run;
  logic [31:0] a_lfsr;

  // Instance B: WIDTH=128, DIV_N=4, OUT_W=8
  logic         b_rst, b_load, b_en, b_ready;
  logic [127:0] b_seed;
  logic [7:0]   b_data;
  logic         b_valid, b_ks, b_sz, b_run;
  logic [127:0] b_lfsr;

`ifdef PRNG_LFSR_STREAM_STEP_CNT_EN
  logic [63:0] a_steps, b_steps;
`endif

  prng_lfsr_stream #(.WIDTH(32), .DIV_N(1), .OUT_W(8)) u_dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_seed_load(a_load), .i_seed(a_seed), .i_en(a_en),
    .o_ks_data(a_data), .o_ks_valid(a_valid), .i_ks_ready(a_ready), .o_lfsr(a_lfsr),
    .o_keystream(a_ks), .o_seed_zero(a_sz), .o_running(a_run)
`ifdef PRNG_LFSR_STREAM_STEP_CNT_EN
    , .o_step_cnt(a_steps)
`endif
  );

  prng_lfsr_stream #(.WIDTH(128), .DIV_N(4), .OUT_W(8)) u_dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_seed_load(b_load), .i_seed(b_seed), .i_en(b_en),
    .o_ks_data(b_data), .o_ks_valid(b_valid), .i_ks_ready(b_ready), .o_lfsr(b_lfsr),
    .o_keystream(b_ks), .o_seed_zero(b_sz), .o_running(b_run)
`ifdef PRNG_LFSR_STREAM_STEP_CNT_EN
    , .o_step_cnt(b_steps)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: counts productive cycles since the last step and
  // collects emitted bits until a full word is available.
  typedef struct {
    int           width;
    int           divn;
    int           outw;
    logic [127:0] lfsr;
    bit           running;
    int           phase;
    int           nbits;
    logic [31:0]  acc;
    logic [31:0]  data;
    bit           valid;
    bit           seed_zero;
    longint       steps;
  } model_t;

  model_t ma, mb;

  function automatic logic [127:0] ones(input int w);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic fb_of(input logic [127:0] s, input int w);
    int  t[4];
    logic r;
    case (w)
      128:     t = '{128, 126, 101, 99};
      64:      t = '{64, 63, 61, 60};
      default: t = '{32, 22, 2, 1};
    endcase
    r = 1'b0;
    for (int i = 0; i < 4; i++) r = r ^ s[t[i]-1];
    return r;
  endfunction

  function automatic model_t model_next(input model_t m, input bit rst, input bit load,
                                        input logic [127:0] seed, input bit en, input bit ready);
    model_t n;
    bit     done;
    logic   kbit;
    n    = m;
    done = 1'b0;
    if (rst) begin
      n.lfsr = ones(m.width); n.running = 1'b0; n.phase = 0; n.nbits = 0;
      n.acc = '0; n.data = '0; n.valid = 1'b0; n.seed_zero = 1'b0; n.steps = 0;
    end else if (load) begin
      n.lfsr = (seed == '0) ? ones(m.width) : seed;
      n.running = 1'b1; n.phase = 0; n.nbits = 0; n.acc = '0;
      n.valid = 1'b0; n.seed_zero = (seed == '0); n.steps = 0;
    end else begin
      n.seed_zero = 1'b0;
      if (m.running && en && !(m.valid && !ready)) begin
        n.phase = m.phase + 1;
        if (n.phase == m.divn) begin
          n.phase = 0;
          kbit    = m.lfsr[m.width-1];
          n.lfsr  = ((m.lfsr << 1) | 128'(fb_of(m.lfsr, m.width))) & ones(m.width);
          n.acc   = (m.acc << 1) | 32'(kbit);
          n.nbits = m.nbits + 1;
          n.steps = m.steps + 1;
          if (n.nbits == m.outw) begin
            n.data  = n.acc & ((32'd1 << m.outw) - 32'd1);
            n.valid = 1'b1;
            n.nbits = 0;
            n.acc   = '0;
            done    = 1'b1;
          end
        end
      end
      if (m.valid && ready && !done) n.valid = 1'b0;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic compare_all();
    chk("a.lfsr",      128'(a_lfsr),  ma.lfsr);
    chk("a.valid",     128'(a_valid), 128'(ma.valid));
    chk("a.data",      128'(a_data),  128'(ma.data));
    chk("a.seed_zero", 128'(a_sz),    128'(ma.seed_zero));
    chk("a.running",   128'(a_run),   128'(ma.running));
    chk("a.keystream", 128'(a_ks),    128'(ma.lfsr[31]));
    chk("b.lfsr",      b_lfsr,        mb.lfsr);
    chk("b.valid",     128'(b_valid), 128'(mb.valid));
    chk("b.data",      128'(b_data),  128'(mb.data));
    chk("b.seed_zero", 128'(b_sz),    128'(mb.seed_zero));
    chk("b.running",   128'(b_run),   128'(mb.running));
    chk("b.keystream", 128'(b_ks),    128'(mb.lfsr[127]));
`ifdef PRNG_LFSR_STREAM_STEP_CNT_EN
    chk("a.step_cnt",  128'(a_steps), 128'(ma.steps));
    chk("b.step_cnt",  128'(b_steps), 128'(mb.steps));
`endif
  endtask

  // One clock: model follows the inputs sampled at the edge, outputs checked 1ns later.
  task automatic clk_step();
    @(posedge clk);
    ma = model_next(ma, a_rst, a_load, 128'(a_seed), a_en, a_ready);
    mb = model_next(mb, b_rst, b_load, b_seed, b_en, b_ready);
    #1;
    compare_all();
  endtask

  task automatic b_reload(input logic [127:0] s);
    b_load = 1'b1; b_seed = s;
    clk_step();
    b_load = 1'b0;
  endtask

  typedef struct {
    bit          load;
    logic [31:0] seed;
    bit          ready;
    logic [31:0] lfsr;
    bit          valid;
    logic [7:0]  data;
    bit          sz;
  } vec_t;

  vec_t         tbl[16];
  logic [127:0] prev;
  logic [127:0] hold_lfsr;
  logic [7:0]   hold_data;
  int           waited;

  initial begin
    ma = '{32, 1, 8, '0, 1'b0, 0, 0, '0, '0, 1'b0, 1'b0, 0};
    mb = '{128, 4, 8, '0, 1'b0, 0, 0, '0, '0, 1'b0, 1'b0, 0};

    tbl[0]  = '{1'b1, 32'h1,         1'b1, 32'h0000_0001, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0003, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0006, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 32'h0,         1'b1, 32'h0000_000D, 1'b0, 8'h00, 1'b0};
    tbl[4]  = '{1'b1, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0001, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0003, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0006, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{1'b0, 32'h0,         1'b1, 32'h0000_000D, 1'b0, 8'h00, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,         1'b1, 32'h0000_001B, 1'b0, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 32'h0,         1'b1, 32'h0000_0036, 1'b0, 8'h00, 1'b0};
    tbl[11] = '{1'b0, 32'h0,         1'b1, 32'h0000_006D, 1'b0, 8'h00, 1'b0};
    tbl[12] = '{1'b0, 32'h0,         1'b1, 32'h0000_00DB, 1'b1, 8'h80, 1'b0};
    tbl[13] = '{1'b0, 32'h0,         1'b1, 32'h0000_01B6, 1'b0, 8'h80, 1'b0};
    tbl[14] = '{1'b1, 32'h0,         1'b1, 32'hFFFF_FFFF, 1'b0, 8'h80, 1'b1};
    tbl[15] = '{1'b0, 32'h0,         1'b1, 32'hFFFF_FFFE, 1'b0, 8'h80, 1'b0};

    a_rst = 1'b1; a_load = 1'b0; a_seed = '0; a_en = 1'b0; a_ready = 1'b0;
    b_rst = 1'b1; b_load = 1'b0; b_seed = '0; b_en = 1'b0; b_ready = 1'b0;
    clk_step();
    clk_step();

    chk("reset a.lfsr",      128'(a_lfsr),  128'hFFFF_FFFF);
    chk("reset a.valid",     128'(a_valid), 128'd0);
    chk("reset a.data",      128'(a_data),  128'd0);
    chk("reset a.running",   128'(a_run),   128'd0);
    chk("reset a.seed_zero", 128'(a_sz),    128'd0);
    chk("reset b.lfsr",      b_lfsr,        {128{1'b1}});
    chk("reset b.running",   128'(b_run),   128'd0);

    a_rst = 1'b0; b_rst = 1'b0;
    a_en = 1'b1; b_en = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
    repeat (3) clk_step();
    chk("idle a.lfsr held", 128'(a_lfsr), 128'hFFFF_FFFF);
    chk("idle b.lfsr held", b_lfsr, {128{1'b1}});
    b_en = 1'b0;

    // Constant vectors on instance A
    for (int i = 0; i < 16; i++) begin
      a_load = tbl[i].load; a_seed = tbl[i].seed; a_ready = tbl[i].ready; a_en = 1'b1;
      clk_step();
      $display("vec %0d: load=%0d seed=%h lfsr=%h valid=%0d data=%h", i, tbl[i].load,
               tbl[i].seed, a_lfsr, a_valid, a_data);
      chk($sformatf("vec%0d.lfsr", i),      128'(a_lfsr),  128'(tbl[i].lfsr));
      chk($sformatf("vec%0d.valid", i),     128'(a_valid), 128'(tbl[i].valid));
      chk($sformatf("vec%0d.data", i),      128'(a_data),  128'(tbl[i].data));
      chk($sformatf("vec%0d.seed_zero", i), 128'(a_sz),    128'(tbl[i].sz));
      chk($sformatf("vec%0d.running", i),   128'(a_run),   128'd1);
      chk($sformatf("vec%0d.keystream", i), 128'(a_ks),   128'(tbl[i].lfsr[31]));
    end
    a_load = 1'b0; a_en = 1'b0;

    // Instance B: LFSR changes on every 4th enabled cycle
    b_en = 1'b1; b_ready = 1'b1;
    b_reload({$urandom, $urandom, $urandom, $urandom | 32'h1});
    prev = b_lfsr;
    for (int i = 1; i <= 12; i++) begin
      clk_step();
      chk($sformatf("div4 step cycle %0d", i), 128'(b_lfsr != prev), 128'(i % 4 == 0));
      prev = b_lfsr;
    end
    $display("seq div4: 12 cycles observed, lfsr=%h", b_lfsr);

    // Three disabled cycles push the first step out by three cycles
    b_reload({$urandom, $urandom, $urandom, $urandom | 32'h1});
    prev = b_lfsr;
    for (int i = 1; i <= 8; i++) begin
      b_en = !(i >= 3 && i <= 5);
      clk_step();
      chk($sformatf("en gap cycle %0d", i), 128'(b_lfsr != prev), 128'(i == 7));
      prev = b_lfsr;
    end
    b_en = 1'b1;
    $display("seq en gap: lfsr=%h", b_lfsr);

    // Backpressure: first word after 32 cycles, then frozen for 20 cycles
    b_ready = 1'b0;
    b_reload(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    waited = 0;
    while (!b_valid && waited < 200) begin
      clk_step();
      waited++;
    end
    chk("first word latency", 128'(waited), 128'd32);
    hold_lfsr = b_lfsr; hold_data = b_data;
    for (int i = 0; i < 20; i++) begin
      clk_step();
      chk("stall lfsr frozen", b_lfsr, hold_lfsr);
      chk("stall data frozen", 128'(b_data), 128'(hold_data));
      chk("stall valid held", 128'(b_valid), 128'd1);
    end
    b_ready = 1'b1;
    clk_step();
    chk("accept clears valid", 128'(b_valid), 128'd0);
    prev = b_lfsr;
    for (int i = 1; i <= 3; i++) begin
      clk_step();
      chk($sformatf("resume cycle %0d", i), 128'(b_lfsr != prev), 128'(i == 3));
      prev = b_lfsr;
    end
    $display("seq stall: word=%h accepted after 20 stalled cycles", hold_data);

    // Seed load while a word is pending discards it
    b_ready = 1'b0;
    waited = 0;
    while (!b_valid && waited < 200) begin
      clk_step();
      waited++;
    end
    chk("pending word present", 128'(b_valid), 128'd1);
    b_reload(128'h5);
    chk("load drops pending", 128'(b_valid), 128'd0);
    chk("load sets lfsr", b_lfsr, 128'h5);
    b_ready = 1'b1;
    $display("seq load-discard: lfsr=%h valid=%0d", b_lfsr, b_valid);

    // Reset mid-word returns to IDLE and stays there without a load
    repeat (10) clk_step();
    b_rst = 1'b1;
    clk_step();
    b_rst = 1'b0;
    chk("midrst valid", 128'(b_valid), 128'd0);
    chk("midrst running", 128'(b_run), 128'd0);
    chk("midrst lfsr", b_lfsr, {128{1'b1}});
    for (int i = 0; i < 10; i++) begin
      clk_step();
      chk("post-reset lfsr held", b_lfsr, {128{1'b1}});
    end
    $display("seq mid-reset: running=%0d lfsr=%h", b_run, b_lfsr);

    // Zero seed on B: default seed substituted, pulse lasts one cycle
    b_reload(128'h0);
    chk("zero seed lfsr", b_lfsr, {128{1'b1}});
    chk("zero seed pulse", 128'(b_sz), 128'd1);
    chk("zero seed running", 128'(b_run), 128'd1);
    clk_step();
    chk("zero seed pulse ends", 128'(b_sz), 128'd0);

    // Randomised traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      a_rst   = ($urandom_range(0, 499) == 0);
      a_load  = ($urandom_range(0, 59) == 0);
      a_seed  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      a_en    = ($urandom_range(0, 3) != 0);
      a_ready = ($urandom_range(0, 9) < 6);
      b_rst   = ($urandom_range(0, 499) == 0);
      b_load  = ($urandom_range(0, 59) == 0);
      b_seed  = ($urandom_range(0, 3) == 0) ? 128'h0 : {$urandom, $urandom, $urandom, $urandom};
      b_en    = ($urandom_range(0, 3) != 0);
      b_ready = ($urandom_range(0, 9) < 6);
      clk_step();
    end
    $display("random: 3000 cycles applied");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
